// File: rtl/hkspi_pkg.sv
// hkspi_pkg: command field positions and FSM state type shared by the housekeeping SPI responder
package hkspi_pkg;
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RD_BIT  = 6;
  localparam int CMD_CNT_MSB = 5;
  localparam int CMD_CNT_LSB = 3;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
endpackage

// File: rtl/hkspi_sync_edge.sv
// hkspi_sync_edge: N-stage synchronizer with one-cycle rise/fall pulses on the synchronized level
// Ports: clock, reset (async, active high); d asynchronous input; q synchronized level; rise/fall edge pulses.
module hkspi_sync_edge #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [N:0] s;
  always_ff @(posedge clock or posedge reset)
    if (reset) s <= '0;
    else s <= {s[N-1:0], d};
  assign q = s[N-1];
  assign rise = s[N-1] & ~s[N];
  assign fall = ~s[N-1] & s[N];
endmodule

// File: rtl/hkspi_responder.sv
// hkspi_responder: housekeeping SPI slave turning a CSB/SCK/SDI command stream into register-port strobes
// Ports: clock, reset (async, active high); CSB/SCK/SDI/SDO/sdo_oe mode-0 SPI pins oversampled in clock;
//        reg_addr/reg_wdata/reg_wstb/reg_rstb/reg_rdata byte-wide register port; busy = synchronized CSB low.
module hkspi_responder
  import hkspi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       CSB,
  input  logic       SCK,
  input  logic       SDI,
  output logic       SDO,
  output logic       sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wstb,
  output logic       reg_rstb,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  state_t state, state_d;
  logic csb_s, csb_rise, csb_fall, sck_rise, sck_fall, unused_sck, sdi_s;
  logic [SYNC_STAGES-1:0] sdi_sr;
  logic [2:0] bit_cnt, remaining;
  logic [7:0] rx, tx, rx_next;
  logic cmd_rd, cmd_wr, inc_pend, more_pend, cap_pend, sdo_q, armed, byte_end, cmd_ok;
  hkspi_sync_edge #(.N(SYNC_STAGES)) u_csb (
    .clock(clock), .reset(reset), .d(CSB), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
  );
  hkspi_sync_edge #(.N(SYNC_STAGES)) u_sck (
    .clock(clock), .reset(reset), .d(SCK), .q(unused_sck), .rise(sck_rise), .fall(sck_fall)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) sdi_sr <= '0;
    else sdi_sr <= {sdi_sr[SYNC_STAGES-2:0], SDI};
  assign sdi_s = sdi_sr[SYNC_STAGES-1];
  assign rx_next = {rx[6:0], sdi_s};
  assign byte_end = sck_rise && bit_cnt == 3'd7;
  assign cmd_ok = (rx_next[CMD_WR_BIT] | rx_next[CMD_RD_BIT]) && rx_next[CMD_CNT_LSB-1:0] == '0;
  // The synchronizer clears to "CSB low", so a fall is only seen after CSB has been high at least once;
  // armed keeps busy quiet until that first genuine deselect after reset.
  assign busy = ~csb_s & armed;
  assign sdo_oe = state == DATA && cmd_rd && !csb_s;
  assign SDO = sdo_q & sdo_oe;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (csb_s) state_d = IDLE;
    else if (state == IDLE && csb_fall) state_d = CMD;
    else if (byte_end && state == CMD) state_d = cmd_ok ? ADDR : DONE;
    else if (byte_end && state == ADDR) state_d = DATA;
    else if (byte_end && state == DATA && remaining == 3'd1) state_d = DONE;
  end
  // Byte end -> (wstb) -> address increment + prefetch rstb -> capture flag -> tx load: each step
  // one clock apart so wstb/rstb never overlap and the new address is stable for the read.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bit_cnt <= '0;
      remaining <= '0;
      rx <= '0;
      tx <= '0;
      cmd_rd <= 1'b0;
      cmd_wr <= 1'b0;
      inc_pend <= 1'b0;
      more_pend <= 1'b0;
      cap_pend <= 1'b0;
      sdo_q <= 1'b0;
      armed <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_wstb <= 1'b0;
      reg_rstb <= 1'b0;
    end else begin
      reg_wstb <= 1'b0;
      reg_rstb <= 1'b0;
      inc_pend <= 1'b0;
      cap_pend <= reg_rstb;
      armed <= armed | csb_rise;
      if (cap_pend) tx <= reg_rdata;
      if (csb_fall) begin
        bit_cnt <= '0;
        sdo_q <= 1'b0;
      end else if (sck_rise && state inside {CMD, ADDR, DATA}) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx <= rx_next;
      end
      if (byte_end && state == CMD)
        {cmd_wr, cmd_rd, remaining} <= {rx_next[CMD_WR_BIT], rx_next[CMD_RD_BIT], rx_next[CMD_CNT_MSB:CMD_CNT_LSB]};
      if (byte_end && state == ADDR) begin
        reg_addr <= rx_next;
        reg_rstb <= cmd_rd;
      end
      if (byte_end && state == DATA) begin
        reg_wstb <= cmd_wr;
        if (cmd_wr) reg_wdata <= rx_next;
        inc_pend <= 1'b1;
        more_pend <= remaining != 3'd1;
        if (remaining != 3'd0) remaining <= remaining - 3'd1;
      end
      if (inc_pend) begin
        reg_addr <= reg_addr + 8'd1;
        reg_rstb <= cmd_rd && more_pend && !csb_s;
      end
      if (sck_fall && state == DATA && cmd_rd) begin
        sdo_q <= tx[7];
        tx <= {tx[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_hkspi_responder.sv
// tb_hkspi_responder: randomized and directed SPI transfers checked against a register-level transaction model
module tb_hkspi_responder;
  logic clock = 1'b0, reset, CSB, SCK, SDI, SDO, sdo_oe, reg_wstb, reg_rstb, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  always #5 clock = ~clock;
  hkspi_responder #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .CSB(CSB), .SCK(SCK), .SDI(SDI), .SDO(SDO), .sdo_oe(sdo_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstb(reg_wstb), .reg_rstb(reg_rstb),
    .reg_rdata(reg_rdata), .busy(busy)
  );
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_a [$], wr_a [$], wr_d [$];
  logic [7:0] exp_ra [$], exp_wa [$], exp_wd [$];
  logic [7:0] tx_buf [64], rx_buf [64], oe_buf [64], exp_oe [64], exp_so [64];
  int both_cnt = 0, n_cmp = 0, n_bad = 0;
  logic pre_we = 1'b0;
  logic [7:0] pre_a, pre_d;
  // register-file side of the bus: read data valid the cycle after reg_rstb, garbage otherwise
  always @(posedge clock) begin
    reg_rdata <= reg_rstb ? mem[reg_addr] : 8'($urandom);
    if (reg_rstb) rd_a.push_back(reg_addr);
    if (reg_wstb) begin
      wr_a.push_back(reg_addr);
      wr_d.push_back(reg_wdata);
    end
    if (reg_wstb && reg_rstb) both_cnt++;
    if (pre_we) mem[pre_a] <= pre_d;
    else if (reg_wstb) mem[reg_addr] <= reg_wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_reg(input logic [7:0] a, input logic [7:0] d);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    ref_mem[a] = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask
  task automatic spi_xfer(input int nbits, input int half, input bit start, input bit stop);
    if (start) begin
      CSB = 1'b0;
      repeat (half) @(negedge clock);
      check("busy_on", busy, 1);
    end
    for (int i = 0; i < nbits; i++) begin
      SDI = tx_buf[i / 8][7 - i % 8];
      repeat (half) @(negedge clock);
      rx_buf[i / 8][7 - i % 8] = SDO;
      oe_buf[i / 8][7 - i % 8] = sdo_oe;
      SCK = 1'b1;
      repeat (half) @(negedge clock);
      SCK = 1'b0;
    end
    if (stop) begin
      repeat (half) @(negedge clock);
      CSB = 1'b1;
      SDI = 1'b0;
      repeat (2 * half + 4) @(negedge clock);
      check("busy_off", busy, 0);
    end
  endtask
  // Transaction-level prediction: which registers are read/written and what the host sees per byte.
  task automatic predict(input int nbits);
    logic [7:0] c, a, ai;
    int full, n, eff, nrd;
    exp_ra.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int k = 0; k < 64; k++) begin
      exp_oe[k] = 8'h00;
      exp_so[k] = 8'h00;
    end
    c = tx_buf[0];
    a = tx_buf[1];
    if (nbits < 16 || !(c[7] || c[6]) || c[2:0] != 3'd0) return;
    full = (nbits - 16) / 8;
    n = int'(c[5:3]);
    eff = (n == 0 || full < n) ? full : n;
    nrd = !c[6] ? 0 : (n == 0 || full + 1 < n) ? full + 1 : n;
    for (int i = 0; i < nrd; i++) exp_ra.push_back(a + 8'(i));
    for (int i = 0; i < eff; i++) begin
      ai = a + 8'(i);
      if (c[6]) begin
        exp_oe[2 + i] = 8'hFF;
        exp_so[2 + i] = ref_mem[ai];
      end
      if (c[7]) begin
        exp_wa.push_back(ai);
        exp_wd.push_back(tx_buf[2 + i]);
        ref_mem[ai] = tx_buf[2 + i];
      end
    end
  endtask
  task automatic run(input string tag, input int nbits, input int half);
    int rb, wb;
    rb = rd_a.size();
    wb = wr_a.size();
    predict(nbits);
    for (int k = 0; k < 64; k++) begin
      rx_buf[k] = 8'h00;
      oe_buf[k] = 8'h00;
    end
    spi_xfer(nbits, half, 1'b1, 1'b1);
    check({tag, ":nrd"}, rd_a.size() - rb, exp_ra.size());
    for (int i = 0; i < exp_ra.size() && rb + i < rd_a.size(); i++) check({tag, ":rd_addr"}, rd_a[rb + i], exp_ra[i]);
    check({tag, ":nwr"}, wr_a.size() - wb, exp_wa.size());
    for (int i = 0; i < exp_wa.size() && wb + i < wr_a.size(); i++) begin
      check({tag, ":wr_addr"}, wr_a[wb + i], exp_wa[i]);
      check({tag, ":wr_data"}, wr_d[wb + i], exp_wd[i]);
    end
    for (int k = 0; k < nbits / 8; k++) begin
      check({tag, ":oe"}, oe_buf[k], exp_oe[k]);
      check({tag, ":sdo"}, rx_buf[k], exp_so[k]);
    end
  endtask
  initial begin
    logic [7:0] pv [19];
    int rb, wb, nb, diff;
    pv = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
           8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF, 8'h03, 8'h12, 8'h04};
    reset = 1'b1;
    CSB = 1'b1;
    SCK = 1'b0;
    SDI = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outs", {SDO, sdo_oe, reg_wstb, reg_rstb, busy, reg_addr, reg_wdata}, 0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) set_reg(8'(i), 8'($urandom));
    set_reg(8'h03, 8'h11);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h03; tx_buf[2] = 8'h00;
    run("rd1", 24, 6);
    check("rd1_val", rx_buf[2], 8'h11);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h0B; tx_buf[2] = 8'h01;
    run("wr_a", 24, 6);
    tx_buf[2] = 8'h00;
    run("wr_b", 24, 7);
    for (int i = 0; i < 19; i++) set_reg(8'(i), pv[i]);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h00;
    run("stream19", 16 + 19 * 8, 5);
    for (int i = 0; i < 19; i++) check("stream_val", rx_buf[2 + i], pv[i]);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hAA; tx_buf[3] = 8'h55;
    run("wrap", 32, 6);
    tx_buf[0] = 8'h50; tx_buf[1] = 8'h20;
    run("rd2of3", 40, 6);
    check("rd2of3_oe3", oe_buf[4], 8'h00);
    set_reg(8'h05, 8'h81);
    tx_buf[0] = 8'hC0; tx_buf[1] = 8'h05; tx_buf[2] = 8'h3C;
    run("rw", 24, 6);
    check("rw_old", rx_buf[2], 8'h81);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h10; tx_buf[2] = 8'hE7;
    run("abort5", 21, 6);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h10;
    run("after_abort", 24, 6);
    // reset in the middle of a write data byte, CSB left low across the reset
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h30; tx_buf[2] = 8'hC3;
    rb = rd_a.size();
    wb = wr_a.size();
    spi_xfer(19, 6, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check("reset_mid", {SDO, sdo_oe, reg_wstb, reg_rstb, busy, reg_addr, reg_wdata}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tx_buf[0] = 8'hC0; tx_buf[1] = 8'h31;
    spi_xfer(24, 6, 1'b0, 1'b1);
    check("reset_nowr", wr_a.size() - wb, 0);
    check("reset_nord", rd_a.size() - rb, 0);
    tx_buf[0] = 8'h40; tx_buf[1] = 8'h30;
    run("after_reset", 24, 6);
    for (int t = 0; t < 25; t++) begin
      tx_buf[0] = $urandom_range(0, 9) == 0 ? 8'($urandom) : {2'($urandom_range(1, 3)), 3'($urandom), 3'b000};
      for (int k = 1; k < 8; k++) tx_buf[k] = 8'($urandom);
      nb = $urandom_range(0, 9) == 0 ? $urandom_range(1, 15) : 16 + 8 * $urandom_range(0, 4) + $urandom_range(0, 7);
      run("rand", nb, $urandom_range(5, 8));
    end
    check("wstb_rstb_overlap", both_cnt, 0);
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
    check("regfile", diff, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
